// File: rtl/fp_addsub_resp_if.sv
// Valid/ready streaming interface carrying data, framing, a ctl tag and an error flag.
interface if_axi_stream #(
  parameter int unsigned DAT_BITS = 8,
  parameter int unsigned CTL_BITS = 8
);
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;

    modport source (output val, sop, eop, err, dat, ctl, input rdy);
    modport sink   (input val, sop, eop, dat, ctl, output rdy);
endinterface

// File: rtl/fp_addsub_resp.sv
// Word-serial modular add/subtract: collects DIV operand beats, computes (a+b) or (a-b) mod P,
// and streams the result back word 0 first with the request's ctl tag.
module fp_addsub_resp #(
    parameter int unsigned         FE_BITS    = 384,
    parameter int unsigned         ARITH_BITS = 64,
    parameter logic [FE_BITS-1:0]  P          = '0,
    parameter bit                  SUB        = 1'b0,
    parameter int unsigned         CTL_BITS   = 8
) (
    input logic           i_clk,
    input logic           i_rst_n,
    if_axi_stream.sink    i_op_if,
    if_axi_stream.source  o_res_if
);

    localparam int unsigned DIV   = FE_BITS / ARITH_BITS;
    localparam int unsigned CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DIV);
    localparam logic [FE_BITS:0] P_EXT = {1'b0, P};

    typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;

    state_t state, state_next;

    logic                  rdy_q;
    logic [FE_BITS-1:0]    a_q, b_q, res_q;
    logic [CNT_W-1:0]      in_cnt, out_cnt;
    logic                  bad_q;
    logic [CTL_BITS-1:0]   ctl_q;

    logic                  val_q, sop_q, eop_q, err_q;
    logic [ARITH_BITS-1:0] dat_q;
    logic [CTL_BITS-1:0]   octl_q;

    logic                  op_fire, res_fire, out_load, out_last;
    logic [CNT_W-1:0]      idx, in_cnt_next;
    logic                  bad_next;
    logic [FE_BITS-1:0]    a_next, b_next;
    logic [FE_BITS:0]      sum_ext;
    logic [FE_BITS-1:0]    add_res, diff, sub_res, calc_res;
    logic [ARITH_BITS-1:0] out_word;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (op_fire && i_op_if.eop) state_next = CALC;
            CALC: state_next = SEND;
            SEND: if (res_fire && eop_q) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath decode
    always_comb begin
        op_fire  = i_op_if.val & rdy_q;
        res_fire = val_q & o_res_if.rdy;

        // A sop beat always restarts word indexing; beats past DIV-1 are discarded
        idx      = i_op_if.sop ? '0 : in_cnt;
        bad_next = ((i_op_if.sop || in_cnt == '0) ? 1'b0 : bad_q)
                   | (i_op_if.eop ? (idx != LAST) : (idx == LAST));
        if (i_op_if.eop)      in_cnt_next = '0;
        else if (idx < FULL)  in_cnt_next = idx + 1'b1;
        else                  in_cnt_next = FULL;

        a_next = a_q;
        b_next = b_q;
        for (int unsigned w = 0; w < DIV; w++) begin
            if (idx == CNT_W'(w)) begin
                a_next[w*ARITH_BITS +: ARITH_BITS] = i_op_if.dat[0 +: ARITH_BITS];
                b_next[w*ARITH_BITS +: ARITH_BITS] = i_op_if.dat[ARITH_BITS +: ARITH_BITS];
            end
        end

        sum_ext  = {1'b0, a_q} + {1'b0, b_q};
        add_res  = (sum_ext >= P_EXT) ? FE_BITS'(sum_ext - P_EXT) : sum_ext[FE_BITS-1:0];
        diff     = a_q - b_q;
        sub_res  = (a_q >= b_q) ? diff : diff + P;
        calc_res = bad_q ? '0 : (SUB ? sub_res : add_res);

        // Output register is refilled when empty or when its non-final beat is taken
        out_load = (state == SEND) && (!val_q || (res_fire && !eop_q));
        out_last = (out_cnt == LAST);
        out_word = '0;
        for (int unsigned w = 0; w < DIV; w++) begin
            if (out_cnt == CNT_W'(w)) out_word = res_q[w*ARITH_BITS +: ARITH_BITS];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdy_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            in_cnt <= '0;
            bad_q  <= 1'b0;
            ctl_q  <= '0;
            res_q  <= '0;
        end else begin
            rdy_q <= (state_next == IDLE);
            if (op_fire) begin
                a_q    <= a_next;
                b_q    <= b_next;
                in_cnt <= in_cnt_next;
                bad_q  <= bad_next;
                if (i_op_if.sop) ctl_q <= i_op_if.ctl;
            end
            if (state == CALC) res_q <= calc_res;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            val_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            octl_q  <= '0;
            out_cnt <= '0;
        end else begin
            if (state == CALC) out_cnt <= '0;
            if (out_load) begin
                val_q   <= 1'b1;
                dat_q   <= out_word;
                sop_q   <= (out_cnt == '0);
                eop_q   <= out_last;
                err_q   <= out_last & bad_q;
                octl_q  <= ctl_q;
                out_cnt <= out_cnt + 1'b1;
            end else if (res_fire && eop_q) begin
                val_q <= 1'b0;
                sop_q <= 1'b0;
                eop_q <= 1'b0;
                err_q <= 1'b0;
            end
        end
    end

    assign i_op_if.rdy  = rdy_q;
    assign o_res_if.val = val_q;
    assign o_res_if.sop = sop_q;
    assign o_res_if.eop = eop_q;
    assign o_res_if.err = err_q;
    assign o_res_if.ctl = octl_q;
    assign o_res_if.dat = {{ARITH_BITS{1'b0}}, dat_q};

endmodule

// File: tb/tb_fp_addsub_resp.sv
// Directed bench: an adder and a subtractor instance share one operand stream and back-pressure.
module tb_fp_addsub_resp;

    logic       clk;
    logic       rst_n;
    logic       in_val, in_sop, in_eop;
    logic [7:0] in_dat, in_ctl;
    logic       out_rdy;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    if_axi_stream #(.DAT_BITS(8), .CTL_BITS(8)) op0 ();
    if_axi_stream #(.DAT_BITS(8), .CTL_BITS(8)) op1 ();
    if_axi_stream #(.DAT_BITS(8), .CTL_BITS(8)) res0 ();
    if_axi_stream #(.DAT_BITS(8), .CTL_BITS(8)) res1 ();

    assign op0.val = in_val;  assign op1.val = in_val;
    assign op0.sop = in_sop;  assign op1.sop = in_sop;
    assign op0.eop = in_eop;  assign op1.eop = in_eop;
    assign op0.dat = in_dat;  assign op1.dat = in_dat;
    assign op0.ctl = in_ctl;  assign op1.ctl = in_ctl;
    assign op0.err = 1'b0;    assign op1.err = 1'b0;
    assign res0.rdy = out_rdy;
    assign res1.rdy = out_rdy;

    fp_addsub_resp #(
        .FE_BITS(8), .ARITH_BITS(4), .P(8'd251), .SUB(1'b0), .CTL_BITS(8)
    ) dut_add (
        .i_clk(clk), .i_rst_n(rst_n), .i_op_if(op0), .o_res_if(res0)
    );

    fp_addsub_resp #(
        .FE_BITS(8), .ARITH_BITS(4), .P(8'd251), .SUB(1'b1), .CTL_BITS(8)
    ) dut_sub (
        .i_clk(clk), .i_rst_n(rst_n), .i_op_if(op1), .o_res_if(res1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted
    task automatic drive_beat(input logic [3:0] aw, input logic [3:0] bw,
                              input logic s, input logic e, input logic [7:0] c);
        int k;
        in_val = 1'b1; in_sop = s; in_eop = e; in_dat = {bw, aw}; in_ctl = c;
        k = 0;
        while (!(op0.rdy && op1.rdy) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("op_accept", {31'd0, op0.rdy & op1.rdy}, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        drive_beat(a[3:0], b[3:0], 1'b1, 1'b0, c);
        drive_beat(a[7:4], b[7:4], 1'b0, 1'b1, c);
        in_val = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic expect_resp(input logic [7:0] e_add, input logic [7:0] e_sub,
                               input logic [7:0] c, input logic err, input int lat,
                               input int stall);
        int k;
        logic [7:0]  sh0, sh1;
        logic [15:0] snap;
        k = 0;
        while (!(res0.val && res1.val) && k < 20) begin
            check("op_rdy_busy", {30'd0, op0.rdy, op1.rdy}, 32'd0);
            @(negedge clk);
            k++;
        end
        check("resp_seen", {31'd0, res0.val & res1.val}, 32'd1);
        if (lat != 0) check("latency", k, lat);
        for (int beat = 0; beat < 2; beat++) begin
            if (beat == 0 && stall != 0) begin
                out_rdy = 1'b0;
                snap = {res0.dat, res0.sop, res0.eop, res0.err, res0.val, res0.ctl[3:0]};
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    check("hold_stable", {16'd0, res0.dat, res0.sop, res0.eop, res0.err,
                                          res0.val, res0.ctl[3:0]}, {16'd0, snap});
                    check("hold_op_rdy", {30'd0, op0.rdy, op1.rdy}, 32'd0);
                end
                out_rdy = 1'b1;
            end
            sh0 = e_add >> (beat * 4);
            sh1 = e_sub >> (beat * 4);
            check("add_dat", {24'd0, res0.dat}, {28'd0, sh0[3:0]});
            check("sub_dat", {24'd0, res1.dat}, {28'd0, sh1[3:0]});
            check("val", {30'd0, res0.val, res1.val}, 32'd3);
            check("sop", {30'd0, res0.sop, res1.sop}, (beat == 0) ? 32'd3 : 32'd0);
            check("eop", {30'd0, res0.eop, res1.eop}, (beat == 1) ? 32'd3 : 32'd0);
            check("err", {30'd0, res0.err, res1.err}, (beat == 1 && err) ? 32'd3 : 32'd0);
            check("ctl", {16'd0, res0.ctl, res1.ctl}, {16'd0, c, c});
            @(negedge clk);
        end
        check("post_val", {30'd0, res0.val, res1.val}, 32'd0);
        check("post_op_rdy", {30'd0, op0.rdy, op1.rdy}, 32'd3);
    endtask

    initial begin
        rst_n = 1'b0; in_val = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_dat = '0; in_ctl = '0; out_rdy = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_op_rdy", {30'd0, op0.rdy, op1.rdy}, 32'd0);
        check("rst_res_flags", {24'd0, res0.val, res0.sop, res0.eop, res0.err,
                                res1.val, res1.sop, res1.eop, res1.err}, 32'd0);
        check("rst_res_dat_ctl", {res0.dat, res0.ctl, res1.dat, res1.ctl}, 32'd0);
        rst_n = 1'b1;
        #1 check("rdy_before_edge", {30'd0, op0.rdy, op1.rdy}, 32'd0);
        @(negedge clk);
        check("rdy_after_edge", {30'd0, op0.rdy, op1.rdy}, 32'd3);

        // 250+3 wraps to 2; 250-3 = 247
        send_frame(8'd250, 8'd3, 8'h0B);
        expect_resp(8'd2, 8'd247, 8'h0B, 1'b0, 2, 0);
        // 3+250 = 2; 3-250+251 = 4
        send_frame(8'd3, 8'd250, 8'h21);
        expect_resp(8'd2, 8'd4, 8'h21, 1'b0, 2, 0);
        // 200+50 = 250 (< P); 200-50 = 150
        send_frame(8'd200, 8'd50, 8'h33);
        expect_resp(8'd250, 8'd150, 8'h33, 1'b0, 2, 0);
        // Back-pressure on beat 0: 150 / 50
        send_frame(8'd100, 8'd50, 8'h44);
        expect_resp(8'd150, 8'd50, 8'h44, 1'b0, 2, 5);

        // Short frame (sop+eop on beat 0) -> zero result, err on eop beat
        drive_beat(4'h5, 4'h6, 1'b1, 1'b1, 8'h5A);
        in_val = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        expect_resp(8'd0, 8'd0, 8'h5A, 1'b1, 2, 0);
        // Recovery: 7+9 = 16; 7-9+251 = 249
        send_frame(8'd7, 8'd9, 8'h66);
        expect_resp(8'd16, 8'd249, 8'h66, 1'b0, 2, 0);

        // Reset during SEND after beat 0 was taken
        send_frame(8'd1, 8'd2, 8'h77);
        n = 0;
        while (!res0.val && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_beat0", {29'd0, res0.val, res0.sop, res0.eop}, 32'd6);
        @(negedge clk);
        check("rst_mid_beat1", {30'd0, res0.eop, res1.eop}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("rst_mid_val", {30'd0, res0.val, res1.val}, 32'd0);
        check("rst_mid_op_rdy", {30'd0, op0.rdy, op1.rdy}, 32'd0);
        check("rst_mid_dat", {16'd0, res0.dat, res1.dat}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_no_beat", {30'd0, res0.val, res1.val}, 32'd0);
        end
        rst_n = 1'b1;
        #1 check("rst_rel_rdy_pre", {30'd0, op0.rdy, op1.rdy}, 32'd0);
        @(negedge clk);
        check("rst_rel_rdy", {30'd0, op0.rdy, op1.rdy}, 32'd3);
        check("rst_rel_val", {30'd0, res0.val, res1.val}, 32'd0);
        // 128+200 = 328-251 = 77; 128-200+251 = 179
        send_frame(8'd128, 8'd200, 8'h88);
        expect_resp(8'd77, 8'd179, 8'h88, 1'b0, 2, 0);

        // Back-to-back with input val held high; operands >= P get one correction only
        send_frame(8'd255, 8'd255, 8'h55);
        in_val = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_dat = 8'h0B; in_ctl = 8'hAA;
        expect_resp(8'd3, 8'd0, 8'h55, 1'b0, 2, 0);
        send_frame(8'd251, 8'd0, 8'hAA);
        expect_resp(8'd0, 8'd251, 8'hAA, 1'b0, 2, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
